// File: rtl/pavana_ooo_slave_4tag.sv
// Tagged out-of-order memory responder: up to four reads outstanding, each tagged by
// its slot index, with responses returned as their address-dependent latencies expire.

module pavana_ooo_slave_4tag_slot #(
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          alloc_i,
    input  logic [CW-1:0] lat_i,
    input  logic [31:0]   data_i,
    input  logic          free_i,
    output logic          busy_o,
    output logic          ready_o,
    output logic [31:0]   data_o
);
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (alloc_i) begin
            busy_d = 1'b1;
            cnt_d  = lat_i;
            data_d = data_i;
        end else begin
            if (free_i) busy_d = 1'b0;
            // A ready slot that lost arbitration simply parks at zero.
            if (busy_q && cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign busy_o  = busy_q;
    assign ready_o = busy_q && (cnt_q == '0);
    assign data_o  = data_q;
endmodule

module pavana_ooo_slave_4tag #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MIN_LAT        = 2,
    parameter int LAT_STEP       = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        cmd,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [1:0]  reqtid,
    output logic        resp,
    output logic [1:0]  resptid,
    output logic [31:0] rdata
);
    localparam int NT = 4;
    localparam int CW = $clog2(MIN_LAT + 3 * LAT_STEP + 1);

    logic [31:0] mem [2**MEM_ADDR_WIDTH];

    logic [MEM_ADDR_WIDTH-1:0] widx;
    logic [CW-1:0]             lat_m1;
    logic [NT-1:0]             busy, ready;
    logic [NT-1:0][31:0]       slot_data;
    logic [1:0]                free_tag, sel_tag;
    logic                      any_free, any_ready, rd_acc;

    logic        resp_q, resp_d;
    logic [1:0]  resptid_q, resptid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        unused_addr;

    assign widx        = addr[MEM_ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr[31:MEM_ADDR_WIDTH+2], addr[1:0]};
    // Counter is loaded with L-1 so the response lands L edges after accept.
    assign lat_m1      = CW'(MIN_LAT - 1 + LAT_STEP * int'(addr[3:2]));

    always_comb begin
        free_tag  = 2'd0;
        any_free  = 1'b0;
        sel_tag   = 2'd0;
        any_ready = 1'b0;
        for (int i = NT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_tag = 2'(i);
                any_free = 1'b1;
            end
            if (ready[i]) begin
                sel_tag   = 2'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign ack    = req & (cmd | any_free);
    assign reqtid = free_tag;
    assign rd_acc = req & ~cmd & any_free;

    always_ff @(posedge clk_i) begin
        if (req && cmd) mem[widx] <= wdata;
    end

    for (genvar t = 0; t < NT; t++) begin : g_slot
        pavana_ooo_slave_4tag_slot #(.CW(CW)) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .alloc_i (rd_acc && (free_tag == 2'(t))),
            .lat_i   (lat_m1),
            .data_i  (mem[widx]),
            .free_i  (any_ready && (sel_tag == 2'(t))),
            .busy_o  (busy[t]),
            .ready_o (ready[t]),
            .data_o  (slot_data[t])
        );
    end

    always_comb begin
        resp_d    = any_ready;
        resptid_d = any_ready ? sel_tag : resptid_q;
        rdata_d   = any_ready ? slot_data[sel_tag] : rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q    <= 1'b0;
            resptid_q <= 2'd0;
            rdata_q   <= '0;
        end else begin
            resp_q    <= resp_d;
            resptid_q <= resptid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign resp    = resp_q;
    assign resptid = resptid_q;
    assign rdata   = rdata_q;
endmodule

// File: tb/tb_pavana_ooo_slave_4tag.sv
// Bench for pavana_ooo_slave_4tag: ready-time reference model feeds an expected-response
// queue; a separate monitor pops it on every resp pulse.

module tb_pavana_ooo_slave_4tag;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, cmd = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ack, resp;
    logic [1:0]  reqtid, resptid;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    pavana_ooo_slave_4tag dut (
        .clk_i(clk), .rst_i(rst), .req(req), .addr(addr), .cmd(cmd), .wdata(wdata),
        .ack(ack), .reqtid(reqtid), .resp(resp), .resptid(resptid), .rdata(rdata)
    );

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0, n_err = 0, cyc = 0;
    bit          m_busy[4];
    logic [31:0] m_data[4];
    int          m_rdy[4];
    logic [31:0] m_mem[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int w);
        logic [31:0] r;
        r = $urandom;
        return {r[31:12], 6'b0, w[3:0], 2'b00};
    endfunction

    // One request cycle; the model advances at the edge: read ready at accept_cycle + L,
    // lowest ready tag answered at each edge.
    task automatic step(input bit r, input bit c, input int w, input logic [31:0] wd, output bit acc);
        int ft, win;
        bit anyf;
        logic [31:0] a;
        a = mk_addr(w);
        @(negedge clk);
        req = r; cmd = c; addr = a; wdata = wd;
        #1;
        ft = 0; anyf = 0;
        for (int t = 3; t >= 0; t--) if (!m_busy[t]) begin ft = t; anyf = 1; end
        acc = r && (c || anyf);
        chk("ack", 32'(ack), 32'(acc));
        chk("reqtid", 32'(reqtid), 32'(ft));
        @(posedge clk);
        cyc++;
        win = -1;
        for (int t = 3; t >= 0; t--) if (m_busy[t] && m_rdy[t] <= cyc) win = t;
        if (win >= 0) begin
            sbq.push_back('{tag: 2'(win), data: m_data[win], cyc: cyc});
            m_busy[win] = 0;
        end
        if (acc && !c) begin
            m_busy[ft] = 1;
            m_data[ft] = m_mem[w];
            m_rdy[ft]  = cyc + 2 + 3 * (w % 4);
        end
        if (acc && c) m_mem[w] = wd;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, a);
    endtask

    task automatic rd(input int w);
        bit a;
        step(1, 0, w, 32'h0, a);
    endtask

    task automatic wr(input int w, input logic [31:0] d);
        bit a;
        step(1, 1, w, d, a);
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1;
        chk("rst_resp", 32'(resp), 32'h0);
        chk("rst_resptid", 32'(resptid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        for (int t = 0; t < 4; t++) m_busy[t] = 0;
        sbq.delete();
        #1 rst = 1'b0;
    endtask

    // Monitor: every resp pulse must match the oldest expected entry, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (resp) begin
                    if (sbq.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL spurious_resp: got resptid %0d rdata %h, expected none (cycle %0d)",
                                 resptid, rdata, cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("resptid", 32'(resptid), 32'(e.tag));
                        chk("rdata", rdata, e.data);
                        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    e = sbq.pop_front();
                    n_cmp++; n_err++;
                    $display("FAIL missing_resp: got none, expected tag %0d data %h at cycle %0d",
                             e.tag, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int tries;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp", 32'(resp), 32'h0);
        chk("reset_resptid", 32'(resptid), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_ack_idle", 32'(ack), 32'h0);
        chk("reset_reqtid", 32'(reqtid), 32'h0);
        #1 rst = 1'b0;

        for (int w = 0; w < 16; w++) wr(w, $urandom);

        // write then read, minimum latency
        wr(0, 32'hDEADBEEF);
        rd(0);
        idle(4);

        // long read overtaken by a short one
        rd(3);
        rd(0);
        idle(14);

        // fill all tags, stall a fifth read while writes still get through
        for (int i = 0; i < 4; i++) rd(3);
        tries = 0;
        do begin
            step(1, 0, 3, 32'h0, a);
            if (!a) wr(5, $urandom);
            tries++;
        end while (!a && tries < 40);
        chk("stall_released", 32'(a), 32'h1);
        idle(15);

        // two reads become ready on the same cycle
        rd(1);
        idle(2);
        rd(0);
        idle(8);

        // data is captured at accept, unaffected by a later write
        wr(1, 32'h11);
        rd(1);
        wr(1, 32'h22);
        idle(8);
        rd(1);
        idle(8);

        // reset drops outstanding reads
        for (int i = 0; i < 3; i++) rd(3);
        idle(2);
        reset_pulse();
        idle(15);
        rd(0);
        idle(6);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15), $urandom, a);
        idle(25);
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
